lif_spike_layer: RTL and testbench

Leaky integrate-and-fire neuron layer sitting directly downstream of the sparse MVM accelerator. It consumes the accelerator's toggle-signalled result stream (one 8-bit synaptic current per output row) and integrates each value into a per-neuron membrane potential with shift-based leak. After each complete frame it thresholds the potentials and publishes an N-bit spike train, which is fed back as the next spike-train input of the MVM.

---
 rtl/lif_pkg.sv | 7 +
 rtl/lif_neuron_update.sv | 29 ++
 rtl/lif_spike_layer.sv | 119 +++++++++++
 tb/tb_lif_spike_layer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// lif_pkg: shared state encoding and default neuron constants for the LIF spike layer.
package lif_pkg;
    typedef enum logic [1:0] {COLLECT, UPDATE, PUBLISH} state_t;
    localparam int V_W_DEF        = 10;
    localparam int THRESH_DEF     = 200;
    localparam int LEAK_SHIFT_DEF = 3;
endpackage

// File: rtl/lif_neuron_update.sv
// lif_neuron_update: combinational leak, integrate, clamp and fire for one neuron.
//   v      in  V_W    current membrane potential
//   cur    in  VAL_W  synaptic current collected this frame
//   v_next out V_W    potential after leak/add/clamp, zeroed on spike
//   spike  out 1      clamped potential reached THRESH
module lif_neuron_update
    import lif_pkg::*;
#(
    parameter int VAL_W      = 8,
    parameter int V_W        = V_W_DEF,
    parameter int THRESH     = THRESH_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
    input  logic [V_W-1:0]   v,
    input  logic [VAL_W-1:0] cur,
    output logic [V_W-1:0]   v_next,
    output logic             spike
);
    localparam logic [V_W:0] V_MAX = {1'b0, {V_W{1'b1}}};
    logic [V_W:0]   sum;
    logic [V_W-1:0] sat;
    always_comb begin
        // one spare bit so leak-then-add can exceed V_MAX before clamping
        sum    = {1'b0, v} - ({1'b0, v} >> LEAK_SHIFT) + (V_W+1)'(cur);
        sat    = (sum > V_MAX) ? V_MAX[V_W-1:0] : sum[V_W-1:0];
        spike  = 32'(sat) >= THRESH;
        v_next = spike ? '0 : sat;
    end
endmodule

// File: rtl/lif_spike_layer.sv
// lif_spike_layer: leaky integrate-and-fire layer fed by a toggle-signalled current stream.
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        zero potentials, back to COLLECT, index 0, clear drop_flag
//   frame_start  discard partial frame while collecting
//   in_val       synaptic current, valid on each in_toggle level change
//   in_toggle    level-change strobe from the upstream accelerator
//   spike_train  per-neuron spikes of the last completed frame
//   spike_valid  one-cycle pulse while the new spike_train is first presented
//   busy         high while updating or publishing
//   drop_flag    sticky: a toggle arrived while busy
module lif_spike_layer
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = 3,
    parameter int VAL_W      = 8,
    parameter int V_W        = V_W_DEF,
    parameter int THRESH     = THRESH_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 frame_start,
    input  logic [VAL_W-1:0]     in_val,
    input  logic                 in_toggle,
    output logic [N_NEURONS-1:0] spike_train,
    output logic                 spike_valid,
    output logic                 busy,
    output logic                 drop_flag
);
    localparam int            IW   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

    state_t               state, state_d;
    logic                 tog_q, armed, evt, last_idx, last_u, spike;
    logic [IW-1:0]        idx, uidx;
    logic [V_W-1:0]       v [N_NEURONS];
    logic [VAL_W-1:0]     cur [N_NEURONS];
    logic [V_W-1:0]       v_next;
    logic [N_NEURONS-1:0] spk, spk_next;

    // armed keeps the first sampled toggle level after reset from counting as an event
    assign evt         = armed && (in_toggle != tog_q);
    assign last_idx    = idx == LAST;
    assign last_u      = uidx == LAST;
    assign busy        = state != COLLECT;
    assign spike_valid = state == PUBLISH;

    lif_neuron_update #(
        .VAL_W(VAL_W), .V_W(V_W), .THRESH(THRESH), .LEAK_SHIFT(LEAK_SHIFT)
    ) u_update (
        .v(v[uidx]), .cur(cur[uidx]), .v_next(v_next), .spike(spike)
    );

    always_comb begin
        spk_next       = spk;
        spk_next[uidx] = spike;
    end

    always_comb begin
        state_d = state;
        case (state)
            COLLECT: state_d = (!frame_start && evt && last_idx) ? UPDATE : COLLECT;
            UPDATE:  state_d = last_u ? PUBLISH : UPDATE;
            default: state_d = COLLECT;
        endcase
        if (clear) state_d = COLLECT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_q       <= 1'b0;
            armed       <= 1'b0;
            idx         <= '0;
            uidx        <= '0;
            drop_flag   <= 1'b0;
            spike_train <= '0;
            spk         <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v[i]   <= '0;
                cur[i] <= '0;
            end
        end else begin
            tog_q <= in_toggle;
            armed <= 1'b1;
            if (clear) begin
                idx       <= '0;
                uidx      <= '0;
                drop_flag <= 1'b0;
                for (int i = 0; i < N_NEURONS; i++) v[i] <= '0;
            end else begin
                if (busy && evt) drop_flag <= 1'b1;
                case (state)
                    COLLECT: begin
                        if (frame_start) idx <= '0;
                        else if (evt) begin
                            cur[idx] <= in_val;
                            idx      <= last_idx ? '0 : idx + 1'b1;
                            uidx     <= '0;
                        end
                    end
                    UPDATE: begin
                        v[uidx] <= v_next;
                        spk     <= spk_next;
                        uidx    <= last_u ? '0 : uidx + 1'b1;
                        // latched on the last update so it is already valid in PUBLISH
                        if (last_u) spike_train <= spk_next;
                    end
                    default: idx <= '0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lif_spike_layer.sv
// tb_lif_spike_layer: scoreboard bench for two layer instances (default and high threshold).
module tb_lif_spike_layer;
    logic       clk = 0, rst_n = 0, clear = 0, frame_start = 0, in_toggle = 0;
    logic [7:0] in_val = 0;
    logic [2:0] train0, train1;
    logic       valid0, valid1, busy0, busy1, drop0, drop1;

    typedef struct { logic [2:0] train; int cyc; } exp_t;
    exp_t q0[$], q1[$];
    exp_t e0, e1;
    int   mv [2][3];
    int   th [2] = '{200, 1023};
    int   cyc = 0, nvec = 0, nerr = 0;
    logic exp_drop = 0;

    lif_spike_layer dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .frame_start(frame_start),
        .in_val(in_val), .in_toggle(in_toggle), .spike_train(train0),
        .spike_valid(valid0), .busy(busy0), .drop_flag(drop0)
    );
    lif_spike_layer #(.THRESH(1023)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .frame_start(frame_start),
        .in_val(in_val), .in_toggle(in_toggle), .spike_train(train1),
        .spike_valid(valid1), .busy(busy1), .drop_flag(drop1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) if (rst_n && valid0) begin
        if (q0.size() == 0) chk("unexpected_valid0", 1, 0);
        else begin
            e0 = q0.pop_front();
            chk("train0", 32'(train0), 32'(e0.train));
            chk("valid_cycle0", cyc, e0.cyc);
        end
    end

    always @(negedge clk) if (rst_n && valid1) begin
        if (q1.size() == 0) chk("unexpected_valid1", 1, 0);
        else begin
            e1 = q1.pop_front();
            chk("train1", 32'(train1), 32'(e1.train));
            chk("valid_cycle1", cyc, e1.cyc);
        end
    end

    task automatic model_clear();
        foreach (mv[d, k]) mv[d][k] = 0;
        exp_drop = 0;
    endtask

    task automatic model_frame(input int c0, input int c1, input int c2, input int pcyc);
        int   c [3];
        exp_t e;
        c = '{c0, c1, c2};
        for (int d = 0; d < 2; d++) begin
            e.train = '0;
            e.cyc   = pcyc;
            for (int k = 0; k < 3; k++) begin
                int n;
                n = mv[d][k] - mv[d][k] / 8 + c[k];
                if (n > 1023) n = 1023;
                if (n >= th[d]) begin
                    e.train[k] = 1'b1;
                    mv[d][k]   = 0;
                end else mv[d][k] = n;
            end
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic send_val(input int val);
        @(posedge clk); #1;
        in_val    = 8'(val);
        in_toggle = ~in_toggle;
    endtask

    task automatic send_frame(input int a, input int b, input int c, input int drop_at);
        int t;
        send_val(a);
        send_val(b);
        send_val(c);
        t = cyc;
        model_frame(a, b, c, t + 4);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i == drop_at) begin
                in_val    = 8'hff;
                in_toggle = ~in_toggle;
                exp_drop  = 1;
            end
            @(negedge clk);
            chk("busy0", 32'(busy0), 32'(i <= 4));
            chk("busy1", 32'(busy1), 32'(i <= 4));
        end
        chk("drop0", 32'(drop0), 32'(exp_drop));
        chk("drop1", 32'(drop1), 32'(exp_drop));
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear = 1;
        @(posedge clk); #1 clear = 0;
        model_clear();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_train0"}, 32'(train0), 0);
        chk({tag, "_valid0"}, 32'(valid0), 0);
        chk({tag, "_busy0"},  32'(busy0), 0);
        chk({tag, "_drop0"},  32'(drop0), 0);
        chk({tag, "_train1"}, 32'(train1), 0);
        chk({tag, "_busy1"},  32'(busy1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        @(posedge clk); #1 rst_n = 1;
        repeat (2) @(posedge clk);

        send_frame(100, 0, 250, 0);
        send_frame(100, 0, 0, 0);
        send_frame(100, 0, 0, 0);

        pulse_clear();
        repeat (6) send_frame(255, 0, 0, 0);

        send_frame(10, 20, 30, 2);
        send_frame(0, 0, 210, 0);

        send_val(50);
        send_val(60);
        @(posedge clk); #1 frame_start = 1;
        @(posedge clk); #1 frame_start = 0;
        send_frame(0, 0, 210, 0);

        pulse_clear();
        @(negedge clk);
        chk("drop_after_clear0", 32'(drop0), 0);
        chk("drop_after_clear1", 32'(drop1), 0);

        send_val(1);
        send_val(2);
        send_val(3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n     = 0;
        in_toggle = 1;
        model_clear();
        @(negedge clk);
        chk_idle("midreset");
        @(posedge clk); #1 rst_n = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stuck_level_busy0", 32'(busy0), 0);
        send_frame(100, 0, 250, 0);

        repeat (3) @(posedge clk);
        chk("pending0", q0.size(), 0);
        chk("pending1", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
